// File: rtl/perip_uart_tx_pkg.sv
// Shared definitions for the peripheral-side UART transmitter: register map, STATUS bits, CTRL fields, FSM encoding.
// Latency: n/a (constants only); backpressure: n/a.
package perip_uart_tx_pkg;

  localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_DATA_ADDR = 32'h0000_0004;
  localparam logic [31:0] DEF_CMD_ADDR  = 32'h0000_0008;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_000C;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_DIV_LSB = 0;
  localparam int CTRL_DIV_MSB = 15;
  localparam int CTRL_EN_BIT  = 16;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_LOAD_CTRL = 3'd2;
  localparam logic [2:0] ST_LOAD_DATA = 3'd3;
  localparam logic [2:0] ST_ERR       = 3'd4;
  localparam logic [2:0] ST_SET_BUSY  = 3'd5;
  localparam logic [2:0] ST_SHIFT     = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  // A zero divisor would stall the bit timer, so it is treated as 1.
  function automatic logic [15:0] ctrl_div(input logic [31:0] ctrl);
    logic [15:0] div;
    div = ctrl[CTRL_DIV_MSB:CTRL_DIV_LSB];
    ctrl_div = (div == 16'd0) ? 16'd1 : div;
  endfunction

  function automatic logic [31:0] stat_word(input int bit_pos);
    stat_word = 32'h1 << bit_pos;
  endfunction

endpackage

// File: rtl/perip_uart_tx_baud_cnt.sv
// Bit-period timer: tick_o pulses once every div_i cycles after load_i, reloading itself on each tick.
// Latency: first tick div_i cycles after the load edge; backpressure: none, free-running.
module uart_baud_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] reload;

  assign reload = (div_i == 16'd0) ? 16'd0 : div_i - 16'd1;
  assign tick_o = !load_i && (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || cnt_q == 16'd0) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/perip_uart_tx.sv
// UART 8N1 transmitter owning the register-file peripheral port: polls CMD, loads CTRL/TX_DATA, posts STATUS.
// Latency: start bit 3 edges after CMD is seen in IDLE; backpressure: none, CMD stays pending until IDLE.
module perip_uart_tx
  import perip_uart_tx_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR,
  parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [31:0] CMD_ADDR  = DEF_CMD_ADDR,
  parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] rdaddr_perip,
  input  logic [31:0] data_o_perip,
  output logic        write_perip,
  output logic [31:0] wraddr_perip,
  output logic [31:0] data_i_perip,
  output logic        tx_o
);

  logic [2:0]  state_q,   state_d;
  logic [15:0] div_q,     div_d;
  logic        en_q,      en_d;
  logic [7:0]  byte_q,    byte_d;
  logic [9:0]  shift_q,   shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        wr_q,      wr_d;
  logic [31:0] wraddr_q,  wraddr_d;
  logic [31:0] wdata_q,   wdata_d;

  logic        baud_load;
  logic        baud_tick;
  logic        unused_rd;

  assign unused_rd = ^data_o_perip[31:17];

  uart_baud_cnt u_baud_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (baud_load),
    .div_i  (div_q),
    .tick_o (baud_tick)
  );

  always_comb begin
    rdaddr_perip = CMD_ADDR;
    case (state_q)
      ST_LOAD_CTRL: rdaddr_perip = CTRL_ADDR;
      ST_LOAD_DATA: rdaddr_perip = DATA_ADDR;
      default:      rdaddr_perip = CMD_ADDR;
    endcase
  end

  // The line is the LSB of the shifter; it refills with ones so it idles high.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    en_d      = en_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wr_d      = 1'b0;
    wraddr_d  = wraddr_q;
    wdata_d   = wdata_q;
    baud_load = 1'b0;

    case (state_q)
      ST_INIT: begin
        wr_d     = 1'b1;
        wraddr_d = STAT_ADDR;
        wdata_d  = 32'h0;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (data_o_perip[0]) begin
          state_d = ST_LOAD_CTRL;
        end
      end
      ST_LOAD_CTRL: begin
        div_d   = ctrl_div(data_o_perip);
        en_d    = data_o_perip[CTRL_EN_BIT];
        state_d = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        byte_d   = data_o_perip[7:0];
        wr_d     = 1'b1;
        wraddr_d = CMD_ADDR;
        wdata_d  = 32'h0;
        state_d  = en_q ? ST_SET_BUSY : ST_ERR;
      end
      ST_ERR: begin
        wr_d     = 1'b1;
        wraddr_d = STAT_ADDR;
        wdata_d  = stat_word(STAT_ERR);
        state_d  = ST_IDLE;
      end
      ST_SET_BUSY: begin
        wr_d      = 1'b1;
        wraddr_d  = STAT_ADDR;
        wdata_d   = stat_word(STAT_BUSY);
        shift_d   = {1'b1, byte_q, 1'b0};
        bit_cnt_d = 4'd0;
        baud_load = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (baud_tick) begin
          if (bit_cnt_q == 4'd9) begin
            state_d = ST_DONE;
          end else begin
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        wr_d     = 1'b1;
        wraddr_d = STAT_ADDR;
        wdata_d  = stat_word(STAT_DONE);
        shift_d  = '1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      div_q     <= 16'd1;
      en_q      <= 1'b0;
      byte_q    <= 8'h00;
      shift_q   <= '1;
      bit_cnt_q <= 4'd0;
      wr_q      <= 1'b0;
      wraddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      en_q      <= en_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wr_q      <= wr_d;
      wraddr_q  <= wraddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign tx_o         = shift_q[0];
  assign write_perip  = wr_q;
  assign wraddr_perip = wraddr_q;
  assign data_i_perip = wdata_q;

endmodule

// File: tb/tb_perip_uart_tx.sv
// Bench for perip_uart_tx: behavioural register file with bus-write priority, table of frame vectors,
// plus hand-written sequences for same-cycle CMD write and reset in the middle of a frame.
module tb_perip_uart_tx;

  localparam int K_NONE  = 0;
  localparam int K_FRAME = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    logic [31:0] ctrl;
    logic [7:0]  dat;
    logic [31:0] cmd;
    int          div;
    int          kind;
  } vec_t;

  logic        clk;
  logic        rst_i;
  logic [31:0] rdaddr_perip;
  logic [31:0] data_o_perip;
  logic        write_perip;
  logic [31:0] wraddr_perip;
  logic [31:0] data_i_perip;
  logic        tx_o;

  logic [31:0] regs [0:3];
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_dat;

  int          n_checks;
  int          n_err;
  int          wr_cnt;
  int          tx_low_cnt;
  logic [31:0] stat_q[$];
  vec_t        tab[5];

  perip_uart_tx dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rdaddr_perip (rdaddr_perip),
    .data_o_perip (data_o_perip),
    .write_perip  (write_perip),
    .wraddr_perip (wraddr_perip),
    .data_i_perip (data_i_perip),
    .tx_o         (tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_o_perip = regs[rdaddr_perip[3:2]];

  // Bus write is issued after the peripheral write so it wins on a collision.
  always @(posedge clk) begin
    if (write_perip) regs[wraddr_perip[3:2]] <= data_i_perip;
    if (bus_we)      regs[bus_addr[3:2]]     <= bus_dat;
  end

  always @(negedge clk) begin
    if (write_perip) begin
      wr_cnt++;
      if (wraddr_perip == 32'hC) stat_q.push_back(data_i_perip);
    end
    if (tx_o !== 1'b1) tx_low_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] dat);
    bus_we   = 1'b1;
    bus_addr = addr;
    bus_dat  = dat;
    @(negedge clk);
    bus_we   = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input int div, output int lat);
    logic [9:0] f;
    logic       ok;
    f   = {1'b1, b, 1'b0};
    lat = 0;
    while (tx_o !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_start"}, {31'd0, tx_o}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      ok = 1'b1;
      for (int c = 0; c < div; c++) begin
        if (tx_o !== f[k]) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, k), {31'd0, ok ? f[k] : ~f[k]}, {31'd0, f[k]});
    end
    @(negedge clk);
    check({tag, "_done_wr"}, {31'd0, write_perip}, 32'd1);
    check({tag, "_done_addr"}, wraddr_perip, 32'hC);
    check({tag, "_done_dat"}, data_i_perip, 32'h2);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int low0;
    int wr0;
    string tag;
    tag = $sformatf("v%0d", idx);
    stat_q.delete();
    bus_wr(32'h0, v.ctrl);
    bus_wr(32'h4, {24'd0, v.dat});
    bus_wr(32'h8, v.cmd);
    low0 = tx_low_cnt;
    wr0  = wr_cnt;
    case (v.kind)
      K_FRAME: begin
        check_frame(tag, v.dat, v.div, lat);
        check({tag, "_latency"}, lat, 32'd4);
        tick(2);
        check({tag, "_stat_n"}, stat_q.size(), 32'd2);
        check({tag, "_stat0"}, (stat_q.size() > 0) ? stat_q[0] : 32'hFFFF_FFFF, 32'h1);
        check({tag, "_stat1"}, (stat_q.size() > 1) ? stat_q[1] : 32'hFFFF_FFFF, 32'h2);
        check({tag, "_cmd_clr"}, regs[2], 32'h0);
      end
      K_ERR: begin
        tick(20);
        check({tag, "_stat_n"}, stat_q.size(), 32'd1);
        check({tag, "_stat0"}, (stat_q.size() > 0) ? stat_q[0] : 32'hFFFF_FFFF, 32'h4);
        check({tag, "_cmd_clr"}, regs[2], 32'h0);
        check({tag, "_tx_idle"}, tx_low_cnt - low0, 32'd0);
      end
      default: begin
        tick(20);
        check({tag, "_no_wr"}, wr_cnt - wr0, 32'd0);
        check({tag, "_cmd_kept"}, regs[2], v.cmd);
        check({tag, "_tx_idle"}, tx_low_cnt - low0, 32'd0);
      end
    endcase
  endtask

  initial begin
    int lat;
    int n;
    int low0;
    int wr0;

    n_checks   = 0;
    n_err      = 0;
    wr_cnt     = 0;
    tx_low_cnt = 0;
    bus_we     = 1'b0;
    bus_addr   = 32'h0;
    bus_dat    = 32'h0;
    regs[0]    = 32'h0;
    regs[1]    = 32'h0;
    regs[2]    = 32'h0;
    regs[3]    = 32'h7;

    tab[0] = '{ctrl: 32'h0001_0004, dat: 8'hA5, cmd: 32'h0000_0001, div: 4, kind: K_FRAME};
    tab[1] = '{ctrl: 32'h0000_0004, dat: 8'h3C, cmd: 32'h0000_0001, div: 4, kind: K_ERR};
    tab[2] = '{ctrl: 32'h0001_0000, dat: 8'h00, cmd: 32'h0000_0001, div: 1, kind: K_FRAME};
    tab[3] = '{ctrl: 32'h0001_0002, dat: 8'hC3, cmd: 32'hFFFF_FFFF, div: 2, kind: K_FRAME};
    tab[4] = '{ctrl: 32'h0001_0002, dat: 8'h11, cmd: 32'hFFFF_FFFE, div: 2, kind: K_NONE};

    rst_i = 1'b1;
    tick(3);
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_wr", {31'd0, write_perip}, 32'd0);
    check("rst_wraddr", wraddr_perip, 32'h0);
    check("rst_wdata", data_i_perip, 32'h0);
    rst_i = 1'b0;
    low0  = tx_low_cnt;
    wr0   = wr_cnt;
    tick(20);
    check("idle_stat", regs[3], 32'h0);
    check("idle_wr_once", wr_cnt - wr0, 32'd1);
    check("idle_tx_high", tx_low_cnt - low0, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i, tab[i]);

    // Bus re-arms CMD in the very cycle the hardware clears it.
    stat_q.delete();
    bus_wr(32'h0, 32'h0001_0004);
    bus_wr(32'h4, 32'h96);
    bus_wr(32'h8, 32'h1);
    n = 0;
    while (!(write_perip === 1'b1 && wraddr_perip == 32'h8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("race_clr_seen", {31'd0, write_perip}, 32'd1);
    bus_wr(32'h8, 32'h1);
    check_frame("race_f1", 8'h96, 4, lat);
    check("race_cmd_kept", regs[2], 32'h1);
    check_frame("race_f2", 8'h96, 4, lat);
    check("race_f2_lat", lat, 32'd4);
    low0 = tx_low_cnt;
    tick(60);
    check("race_no_third", tx_low_cnt - low0, 32'd0);
    check("race_cmd_clr", regs[2], 32'h0);
    check("race_stat_n", stat_q.size(), 32'd4);

    // Reset while the fifth data bit is on the line.
    bus_wr(32'h0, 32'h0001_0004);
    bus_wr(32'h4, 32'h00);
    bus_wr(32'h8, 32'h1);
    n = 0;
    while (tx_o !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick(20);
    check("mid_bit5_low", {31'd0, tx_o}, 32'd0);
    check("mid_busy", regs[3], 32'h1);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, tx_o}, 32'd1);
    check("mid_rst_wr", {31'd0, write_perip}, 32'd0);
    rst_i = 1'b0;
    wr0   = wr_cnt;
    @(negedge clk);
    check("mid_init_wr", {31'd0, write_perip}, 32'd1);
    check("mid_init_addr", wraddr_perip, 32'hC);
    check("mid_init_dat", data_i_perip, 32'h0);
    @(negedge clk);
    check("mid_stat_clr", regs[3], 32'h0);
    low0 = tx_low_cnt;
    tick(30);
    check("mid_idle_tx", tx_low_cnt - low0, 32'd0);
    check("mid_idle_wr", wr_cnt - wr0, 32'd1);
    run_vec(5, tab[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
